// File: rtl/router_output_arbiter.sv
// Output-port arbiter and wormhole packet sequencer: round-robin grant held
// for header, size and payload flits, with a credit-gated transfer strobe.
module router_output_arbiter #(
  parameter int unsigned NPORTS     = 5,
  parameter int unsigned FLIT_WIDTH = 16,
  parameter int unsigned SIZE_WIDTH = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NPORTS-1:0]     in_valid,
  input  logic [FLIT_WIDTH-1:0] flit_sel,
  input  logic                  credit_i,
  output logic [NPORTS-1:0]     grant,
  output logic                  tx,
  output logic [NPORTS-1:0]     consume,
  output logic                  busy,
  output logic                  pkt_done
);

  localparam int unsigned IDX_W = (NPORTS > 1) ? $clog2(NPORTS) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HEADER  = 2'd1,
    SIZE    = 2'd2,
    PAYLOAD = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic [NPORTS-1:0]       grant_q, grant_d;
  logic [IDX_W-1:0]        last_q, last_d;
  logic [SIZE_WIDTH-1:0]   cnt_q, cnt_d;

  logic [SIZE_WIDTH-1:0]   size_fld;
  logic                    arb_found;
  logic [IDX_W-1:0]        arb_idx;
  logic [NPORTS-1:0]       arb_onehot;
  logic                    unused_flit;

  // Only the low bits of the size flit carry the payload length.
  assign size_fld    = flit_sel[SIZE_WIDTH-1:0];
  assign unused_flit = ^flit_sel;

  // Transfer strobe: only the granted input's valid matters while busy.
  always_comb begin
    busy    = (state_q != IDLE);
    grant   = grant_q;
    tx      = busy & (|(grant_q & in_valid)) & credit_i;
    consume = grant_q & {NPORTS{tx}};
  end

  // Round-robin search starting just after the last served port.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = last_q;
    for (int unsigned i = 1; i <= NPORTS; i++) begin
      if (!arb_found && in_valid[IDX_W'((32'(last_q) + i) % NPORTS)]) begin
        arb_found = 1'b1;
        arb_idx   = IDX_W'((32'(last_q) + i) % NPORTS);
      end
    end
    arb_onehot = NPORTS'(1) << arb_idx;
  end

  // Packet sequencing: next state, grant, pointer and payload counter.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    pkt_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (arb_found) begin
          grant_d = arb_onehot;
          last_d  = arb_idx;
          state_d = HEADER;
        end
      end
      HEADER: begin
        if (tx) state_d = SIZE;
      end
      SIZE: begin
        if (tx) begin
          if (size_fld == '0) begin
            pkt_done = 1'b1;
            grant_d  = '0;
            state_d  = IDLE;
          end else begin
            cnt_d   = size_fld;
            state_d = PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        if (tx) begin
          cnt_d = cnt_q - SIZE_WIDTH'(1);
          if (cnt_q == SIZE_WIDTH'(1)) begin
            pkt_done = 1'b1;
            grant_d  = '0;
            state_d  = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset drops any packet in flight at once.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= IDX_W'(NPORTS - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_router_output_arbiter.sv
// Directed bench for router_output_arbiter with hand-computed expectations.
module tb_router_output_arbiter;

  localparam int unsigned NP = 5;
  localparam int unsigned FW = 16;
  localparam int unsigned SW = 16;

  logic          clock;
  logic          reset;
  logic [NP-1:0] in_valid;
  logic [FW-1:0] flit_sel;
  logic          credit_i;
  logic [NP-1:0] grant;
  logic          tx;
  logic [NP-1:0] consume;
  logic          busy;
  logic          pkt_done;

  int checks;
  int failures;

  router_output_arbiter #(.NPORTS(NP), .FLIT_WIDTH(FW), .SIZE_WIDTH(SW)) dut (
    .clock    (clock),
    .reset    (reset),
    .in_valid (in_valid),
    .flit_sel (flit_sel),
    .credit_i (credit_i),
    .grant    (grant),
    .tx       (tx),
    .consume  (consume),
    .busy     (busy),
    .pkt_done (pkt_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [NP-1:0] g, input logic t,
                            input logic pd, input logic b);
    chk({tag, ".grant"},    32'(grant),    32'(g));
    chk({tag, ".tx"},       32'(tx),       32'(t));
    chk({tag, ".consume"},  32'(consume),  32'(t ? g : 5'b0));
    chk({tag, ".pkt_done"}, 32'(pkt_done), 32'(pd));
    chk({tag, ".busy"},     32'(busy),     32'(b));
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drv(input logic [NP-1:0] iv, input logic [FW-1:0] fs, input logic cr);
    in_valid = iv;
    flit_sel = fs;
    credit_i = cr;
    #1;
  endtask

  logic [NP-1:0] order [6];

  initial begin
    checks   = 0;
    failures = 0;
    order    = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00001};
    reset    = 1'b0;
    in_valid = '0;
    flit_sel = '0;
    credit_i = 1'b0;
    #2;
    expect_out("reset", 5'b0, 1'b0, 1'b0, 1'b0);
    chk("reset.cnt", 32'(dut.cnt_q), 32'd0);
    tick();
    reset = 1'b1;

    // Basic packet: header, size 2, two payload flits
    drv(5'b00001, 16'hABCD, 1'b1); expect_out("t1_idle", 5'b0, 1'b0, 1'b0, 1'b0);
    tick(); drv(5'b00001, 16'hABCD, 1'b1); expect_out("t1_hdr",  5'b00001, 1'b1, 1'b0, 1'b1);
    tick(); drv(5'b00001, 16'h0002, 1'b1); expect_out("t1_size", 5'b00001, 1'b1, 1'b0, 1'b1);
    tick(); drv(5'b00001, 16'h1111, 1'b1); expect_out("t1_p0",   5'b00001, 1'b1, 1'b0, 1'b1);
    tick(); drv(5'b00001, 16'h2222, 1'b1); expect_out("t1_p1",   5'b00001, 1'b1, 1'b1, 1'b1);
    tick(); drv(5'b00001, 16'hABCD, 1'b1); expect_out("t1_rel",  5'b0, 1'b0, 1'b0, 1'b0);

    // Zero-length packet: done on the size flit
    tick(); drv(5'b00001, 16'hABCD, 1'b1); expect_out("t2_hdr",  5'b00001, 1'b1, 1'b0, 1'b1);
    tick(); drv(5'b00001, 16'h0000, 1'b1); expect_out("t2_size", 5'b00001, 1'b1, 1'b1, 1'b1);
    tick(); drv(5'b00000, 16'h0000, 1'b1); expect_out("t2_rel",  5'b0, 1'b0, 1'b0, 1'b0);

    // Restore the pointer so port 0 has first priority
    reset = 1'b0;
    #1;
    reset = 1'b1;

    // Round-robin over all ports with size-1 packets
    for (int p = 0; p < 6; p++) begin
      drv(5'b11111, 16'hABCD, 1'b1); expect_out($sformatf("t3_idle%0d", p), 5'b0, 1'b0, 1'b0, 1'b0);
      tick(); drv(5'b11111, 16'hABCD, 1'b1); expect_out($sformatf("t3_hdr%0d", p),  order[p], 1'b1, 1'b0, 1'b1);
      tick(); drv(5'b11111, 16'h0001, 1'b1); expect_out($sformatf("t3_size%0d", p), order[p], 1'b1, 1'b0, 1'b1);
      tick(); drv(5'b11111, 16'h3333, 1'b1); expect_out($sformatf("t3_pay%0d", p),  order[p], 1'b1, 1'b1, 1'b1);
      tick();
    end

    // Credit stall in payload, size 3
    drv(5'b00001, 16'hABCD, 1'b1); expect_out("t4_idle", 5'b0, 1'b0, 1'b0, 1'b0);
    tick(); drv(5'b00001, 16'hABCD, 1'b1); expect_out("t4_hdr",  5'b00001, 1'b1, 1'b0, 1'b1);
    tick(); drv(5'b00001, 16'h0003, 1'b1); expect_out("t4_size", 5'b00001, 1'b1, 1'b0, 1'b1);
    tick(); drv(5'b00001, 16'h4444, 1'b1); expect_out("t4_p0",   5'b00001, 1'b1, 1'b0, 1'b1);
    chk("t4_p0.cnt", 32'(dut.cnt_q), 32'd3);
    for (int k = 0; k < 3; k++) begin
      tick(); drv(5'b00001, 16'h5555, 1'b0);
      expect_out($sformatf("t4_stall%0d", k), 5'b00001, 1'b0, 1'b0, 1'b1);
      chk($sformatf("t4_stall%0d.cnt", k), 32'(dut.cnt_q), 32'd2);
    end
    tick(); drv(5'b00001, 16'h5555, 1'b1); expect_out("t4_p1", 5'b00001, 1'b1, 1'b0, 1'b1);
    tick(); drv(5'b00001, 16'h6666, 1'b1); expect_out("t4_p2", 5'b00001, 1'b1, 1'b1, 1'b1);
    tick(); drv(5'b00001, 16'hABCD, 1'b1); expect_out("t4_rel", 5'b0, 1'b0, 1'b0, 1'b0);

    // Granted input goes quiet while port 3 requests
    tick(); drv(5'b00001, 16'hABCD, 1'b1); expect_out("t5_hdr",  5'b00001, 1'b1, 1'b0, 1'b1);
    tick(); drv(5'b00001, 16'h0002, 1'b1); expect_out("t5_size", 5'b00001, 1'b1, 1'b0, 1'b1);
    tick(); drv(5'b00001, 16'h7777, 1'b1); expect_out("t5_p0",   5'b00001, 1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 2; k++) begin
      tick(); drv(5'b01000, 16'h8888, 1'b1);
      expect_out($sformatf("t5_hold%0d", k), 5'b00001, 1'b0, 1'b0, 1'b1);
    end
    tick(); drv(5'b01001, 16'h8888, 1'b1); expect_out("t5_p1",  5'b00001, 1'b1, 1'b1, 1'b1);
    tick(); drv(5'b01000, 16'hABCD, 1'b1); expect_out("t5_rel", 5'b0, 1'b0, 1'b0, 1'b0);
    tick(); drv(5'b01000, 16'hABCD, 1'b1); expect_out("t5_p3hdr", 5'b01000, 1'b1, 1'b0, 1'b1);

    // Reset in the middle of a size-5 payload
    tick(); drv(5'b01000, 16'h0005, 1'b1); expect_out("t6_size", 5'b01000, 1'b1, 1'b0, 1'b1);
    tick(); drv(5'b01000, 16'h9999, 1'b1); expect_out("t6_p0",   5'b01000, 1'b1, 1'b0, 1'b1);
    chk("t6_p0.cnt", 32'(dut.cnt_q), 32'd5);
    reset = 1'b0;
    #1;
    expect_out("t6_rst", 5'b0, 1'b0, 1'b0, 1'b0);
    tick();
    expect_out("t6_rst_hold", 5'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    drv(5'b00100, 16'hABCD, 1'b1); expect_out("t6_idle", 5'b0, 1'b0, 1'b0, 1'b0);
    tick(); drv(5'b00100, 16'hABCD, 1'b1); expect_out("t6_grant", 5'b00100, 1'b1, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
